// File: rtl/output_port_rr_arbiter.sv
// Router output-port arbiter: per-input packet FIFOs feeding one registered output
// through a round-robin grant that resumes just past the last winner.
module output_port_rr_arbiter #(
    parameter int NUM_INPUTS = 5,
    parameter int DEST_WIDTH = 8,
    parameter int REQ_WIDTH  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int PKT_W = DEST_WIDTH + REQ_WIDTH + 2 + DATA_WIDTH,
    localparam int SRC_W = $clog2(NUM_INPUTS),
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         in_valid,
    output logic [NUM_INPUTS-1:0]         in_ready,
    input  logic [NUM_INPUTS*PKT_W-1:0]   in_packet,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DEST_WIDTH-1:0]         out_dest,
    output logic [REQ_WIDTH-1:0]          out_req,
    output logic                          out_read,
    output logic                          out_write,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic [NUM_INPUTS*LVL_W-1:0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Handshakes: a transfer happens on a clock edge where valid & ready are both high;
    // valid never depends on ready, and ready here comes only from registered state.

    logic [PKT_W-1:0]      mem [NUM_INPUTS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr [NUM_INPUTS];
    logic [PTR_W-1:0]      rdPtr [NUM_INPUTS];
    logic [LVL_W-1:0]      count [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] notEmpty;
    logic [NUM_INPUTS-1:0] push;
    logic [NUM_INPUTS-1:0] pop;
    logic [SRC_W-1:0]      rrPtr;
    logic [SRC_W-1:0]      grantIdx;
    logic [SRC_W-1:0]      rrNext;
    logic [SRC_W-1:0]      searchIdx;
    logic                  grantValid;
    logic                  loadEn;
    logic [PKT_W-1:0]      headPkt;
    logic [PKT_W-1:0]      outPkt;

    always_comb begin
        in_ready = '0;
        notEmpty = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = (count[i] != LVL_W'(FIFO_DEPTH));
            notEmpty[i] = (count[i] != '0);
        end
    end

    assign push   = in_valid & in_ready;
    assign loadEn = ~out_valid | out_ready;

    // Search order starts at rrPtr and wraps, so the previous winner is checked last.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        searchIdx  = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (int'(rrPtr) + k >= NUM_INPUTS) begin
                searchIdx = SRC_W'(int'(rrPtr) + k - NUM_INPUTS);
            end else begin
                searchIdx = SRC_W'(int'(rrPtr) + k);
            end
            if (!grantValid && notEmpty[searchIdx]) begin
                grantValid = 1'b1;
                grantIdx   = searchIdx;
            end
        end
    end

    assign headPkt = mem[grantIdx][rdPtr[grantIdx]];
    assign pop     = (loadEn && grantValid) ? (NUM_INPUTS'(1) << grantIdx) : '0;
    assign rrNext  = (grantIdx == SRC_W'(NUM_INPUTS - 1)) ? '0 : grantIdx + SRC_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (push[i]) wrPtr[i] <= wrPtr[i] + PTR_W'(1);
                if (pop[i])  rdPtr[i] <= rdPtr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + LVL_W'(1);
                    2'b01:   count[i] <= count[i] - LVL_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (push[i]) mem[i][wrPtr[i]] <= in_packet[i*PKT_W +: PKT_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            outPkt    <= '0;
            out_src   <= '0;
            rrPtr     <= '0;
        end else if (loadEn) begin
            if (grantValid) begin
                out_valid <= 1'b1;
                outPkt    <= headPkt;
                out_src   <= grantIdx;
                rrPtr     <= rrNext;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = outPkt[DATA_WIDTH-1:0];
    assign out_write = outPkt[DATA_WIDTH];
    assign out_read  = outPkt[DATA_WIDTH+1];
    assign out_req   = outPkt[DATA_WIDTH+2 +: REQ_WIDTH];
    assign out_dest  = outPkt[DATA_WIDTH+2+REQ_WIDTH +: DEST_WIDTH];

    always_comb begin
        fifo_level = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            fifo_level[i*LVL_W +: LVL_W] = count[i];
        end
    end

endmodule
